// File: rtl/pedal_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pedal_draw_scheduler
// Purpose  : Dirty-driven pixel writer for the 160x120 VGA adapter. Repaints
//            four pedal status boxes and a 10-segment level meter, one pixel
//            per clock, whenever the displayed state of an object changes.
// Revision : 1.0 - initial release
// ============================================================================
module pedal_draw_scheduler #(
    parameter int          PEDAL_W     = 16,
    parameter int          PEDAL_H     = 8,
    parameter int          PEDAL_Y     = 47,
    parameter int          PEDAL_X0    = 42,
    parameter int          PEDAL_X1    = 66,
    parameter int          PEDAL_X2    = 90,
    parameter int          PEDAL_X3    = 113,
    parameter int          SEG_W       = 4,
    parameter int          SEG_H       = 6,
    parameter int          SEG_PITCH   = 6,
    parameter int          METER_X     = 40,
    parameter int          METER_Y     = 100,
    parameter logic [8:0]  ON_COLOR    = 9'h1C1,
    parameter logic [8:0]  OFF_COLOR   = 9'h100,
    parameter logic [8:0]  LIT_COLOR   = 9'h1B6,
    parameter logic [8:0]  UNLIT_COLOR = 9'h000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  enable,
    input  logic [9:0]  level,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [8:0]  color,
    output logic        write,
    output logic        busy
);

    // Offset counters cover the largest object dimension.
    localparam int c_MAX_P = (PEDAL_W > PEDAL_H) ? PEDAL_W : PEDAL_H;
    localparam int c_MAX_S = (SEG_W > SEG_H) ? SEG_W : SEG_H;
    localparam int c_MAXD  = (c_MAX_P > c_MAX_S) ? c_MAX_P : c_MAX_S;
    localparam int c_OW    = (c_MAXD > 1) ? $clog2(c_MAXD) : 1;

    localparam logic [c_OW-1:0] c_PW_LAST = c_OW'(PEDAL_W - 1);
    localparam logic [c_OW-1:0] c_PH_LAST = c_OW'(PEDAL_H - 1);
    localparam logic [c_OW-1:0] c_SW_LAST = c_OW'(SEG_W - 1);
    localparam logic [c_OW-1:0] c_SH_LAST = c_OW'(SEG_H - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DRAW = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_en_q;
    logic [9:0]       r_lv_q;
    logic [13:0]      r_dirty;
    logic [7:0]       r_ox;
    logic [6:0]       r_oy;
    logic [c_OW-1:0]  r_lx;
    logic [c_OW-1:0]  r_ly;
    logic [c_OW-1:0]  r_cx;
    logic [c_OW-1:0]  r_cy;
    logic [7:0]       r_x;
    logic [6:0]       r_y;
    logic [8:0]       r_color;
    logic             r_write;

    logic [13:0]      w_set;
    logic [13:0]      w_clr;
    logic [3:0]       w_sel;
    logic [3:0]       w_seg;
    logic [7:0]       w_ox;
    logic [6:0]       w_oy;
    logic [c_OW-1:0]  w_lx;
    logic [c_OW-1:0]  w_ly;
    logic [8:0]       w_col;
    logic [c_OW-1:0]  w_cx_inc;
    logic [c_OW-1:0]  w_cy_inc;

    assign x     = r_x;
    assign y     = r_y;
    assign color = r_color;
    assign write = r_write;
    assign busy  = (r_state != c_IDLE);

    assign w_set    = {level ^ r_lv_q, enable ^ r_en_q};
    assign w_cx_inc = r_cx + 1'b1;
    assign w_cy_inc = r_cy + 1'b1;

    // Fixed-priority pick of the lowest-index dirty object; cleared on LOAD.
    always_comb begin
        w_sel = 4'd0;
        for (int i = 13; i >= 0; i--) begin
            if (r_dirty[i]) w_sel = 4'(i);
        end
        w_clr = '0;
        if (r_state == c_LOAD) w_clr[w_sel] = 1'b1;
    end

    // Origin, extent and colour of the selected object from the snapshots.
    always_comb begin
        w_seg = 4'd0;
        w_ox  = 8'(METER_X);
        w_oy  = 7'(METER_Y);
        w_lx  = c_SW_LAST;
        w_ly  = c_SH_LAST;
        w_col = UNLIT_COLOR;
        if (w_sel < 4'd4) begin
            w_oy  = 7'(PEDAL_Y);
            w_lx  = c_PW_LAST;
            w_ly  = c_PH_LAST;
            w_col = r_en_q[w_sel[1:0]] ? ON_COLOR : OFF_COLOR;
            case (w_sel[1:0])
                2'd0:    w_ox = 8'(PEDAL_X0);
                2'd1:    w_ox = 8'(PEDAL_X1);
                2'd2:    w_ox = 8'(PEDAL_X2);
                default: w_ox = 8'(PEDAL_X3);
            endcase
        end else begin
            w_seg = w_sel - 4'd4;
            w_ox  = 8'(METER_X + int'(w_seg) * SEG_PITCH);
            w_col = r_lv_q[w_seg] ? LIT_COLOR : UNLIT_COLOR;
        end
    end

    // Snapshot/dirty tracking and the IDLE/LOAD/DRAW pixel sequencer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_en_q  <= '0;
            r_lv_q  <= '0;
            r_dirty <= '1;
            r_ox    <= '0;
            r_oy    <= '0;
            r_lx    <= '0;
            r_ly    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_write <= 1'b0;
        end else begin
            r_en_q  <= enable;
            r_lv_q  <= level;
            // A set in the same cycle as a clear must win.
            r_dirty <= (r_dirty & ~w_clr) | w_set;
            case (r_state)
                c_IDLE: begin
                    r_write <= 1'b0;
                    if (|r_dirty) r_state <= c_LOAD;
                end
                c_LOAD: begin
                    // First pixel leaves on the same edge that enters DRAW.
                    r_ox    <= w_ox;
                    r_oy    <= w_oy;
                    r_lx    <= w_lx;
                    r_ly    <= w_ly;
                    r_cx    <= '0;
                    r_cy    <= '0;
                    r_x     <= w_ox;
                    r_y     <= w_oy;
                    r_color <= w_col;
                    r_write <= 1'b1;
                    r_state <= c_DRAW;
                end
                c_DRAW: begin
                    if (r_cx == r_lx && r_cy == r_ly) begin
                        r_write <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (r_cx == r_lx) begin
                        r_cx <= '0;
                        r_cy <= w_cy_inc;
                        r_x  <= r_ox;
                        r_y  <= r_oy + 7'(w_cy_inc);
                    end else begin
                        r_cx <= w_cx_inc;
                        r_x  <= r_ox + 8'(w_cx_inc);
                    end
                end
                default: begin
                    r_write <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pedal_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pedal_draw_scheduler
// Purpose  : Scoreboard bench for pedal_draw_scheduler. Expected pixels are
//            queued when inputs change and popped on every write cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pedal_draw_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [3:0]  enable;
    logic [9:0]  level;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  color;
    logic        write;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    logic [23:0] r_exp;
    int          wr_cnt = 0;
    int          busy_cnt = 0;
    int          gap = 0;
    bit          seen = 1'b0;
    logic        prev_wr = 1'b0;
    int          wr0;
    int          n;

    always #5 CLOCK_50 = ~CLOCK_50;

    pedal_draw_scheduler dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enable   (enable),
        .level    (level),
        .x        (x),
        .y        (y),
        .color    (color),
        .write    (write),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected raster of one object, built from the published geometry.
    task automatic push_obj(input int idx, input logic on);
        int px[4] = '{42, 66, 90, 113};
        int ox, oy, w, h;
        logic [8:0] col;
        if (idx < 4) begin
            ox = px[idx]; oy = 47; w = 16; h = 8;
            col = on ? 9'h1C1 : 9'h100;
        end else begin
            ox = 40 + (idx - 4) * 6; oy = 100; w = 4; h = 6;
            col = on ? 9'h1B6 : 9'h000;
        end
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                exp_q.push_back({8'(ox + xx), 7'(oy + yy), col});
    endtask

    task automatic push_all();
        for (int i = 0; i < 4; i++) push_obj(i, enable[i]);
        for (int j = 0; j < 10; j++) push_obj(4 + j, level[j]);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin
            @(posedge CLOCK_50); #2;
            k++;
        end while ((exp_q.size() != 0 || busy) && k < budget);
        check_eq("drain_in_budget", 32'(k < budget), 1);
        repeat (6) @(posedge CLOCK_50);
        #2;
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_queue", exp_q.size(), 0);
        @(negedge CLOCK_50);
    endtask

    task automatic wait_writes(input int target);
        int k = 0;
        while (wr_cnt < target && k < 400) begin
            @(posedge CLOCK_50); #2;
            k++;
        end
        check_eq("reach_pixel", 32'(wr_cnt >= target), 1);
    endtask

    // Monitor: pops one expected pixel per write cycle and checks gaps.
    always @(posedge CLOCK_50) begin
        #1;
        if (!reset) begin
            if (busy) busy_cnt++;
            if (write) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_write", 32'(write), 0);
                end else begin
                    r_exp = exp_q.pop_front();
                    check_eq("pixel_xyc", {8'h0, x, y, color}, {8'h0, r_exp});
                end
                if (!prev_wr && seen) check_eq("gap", gap, 2);
                seen   = 1'b1;
                gap    = 0;
                wr_cnt++;
            end else begin
                gap++;
            end
            prev_wr = write;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 4'h0;
        level  = 10'h000;
        repeat (3) @(posedge CLOCK_50);
        #2;
        check_eq("rst_x", 32'(x), 0);
        check_eq("rst_y", 32'(y), 0);
        check_eq("rst_color", 32'(color), 0);
        check_eq("rst_write", 32'(write), 0);
        check_eq("rst_busy", 32'(busy), 0);

        // Full repaint after reset
        @(negedge CLOCK_50);
        push_all();
        wr0 = wr_cnt; busy_cnt = 0; seen = 1'b0;
        reset = 1'b0;
        wait_idle(2000);
        check_eq("repaint_writes", wr_cnt - wr0, 752);
        check_eq("repaint_busy", busy_cnt, 766);

        // Single pedal toggle: latency and extent
        push_obj(2, 1'b1);
        wr0 = wr_cnt; busy_cnt = 0; seen = 1'b0;
        enable[2] = 1'b1;
        n = 0;
        do begin
            @(posedge CLOCK_50); #2;
            n++;
        end while (!write && n < 10);
        check_eq("latency", n, 3);
        wait_idle(500);
        check_eq("pedal2_writes", wr_cnt - wr0, 128);
        check_eq("pedal2_busy", busy_cnt, 129);

        // Three meter segments at once
        push_obj(4, 1'b1); push_obj(5, 1'b1); push_obj(6, 1'b1);
        wr0 = wr_cnt; busy_cnt = 0; seen = 1'b0;
        level = 10'h007;
        wait_idle(500);
        check_eq("seg3_writes", wr_cnt - wr0, 72);
        check_eq("seg3_busy", busy_cnt, 75);

        // Pedal 0 toggled again while its 50th pixel is on the bus
        push_obj(0, 1'b1);
        wr0 = wr_cnt; seen = 1'b0;
        enable[0] = 1'b1;
        wait_writes(wr0 + 50);
        @(negedge CLOCK_50);
        enable[0] = 1'b0;
        push_obj(0, 1'b0);
        wait_idle(800);
        check_eq("redraw_writes", wr_cnt - wr0, 256);

        // Simultaneous pedal 3 and segment 9 change
        push_obj(3, 1'b1); push_obj(13, 1'b1);
        wr0 = wr_cnt; seen = 1'b0;
        enable[3] = 1'b1;
        level[9]  = 1'b1;
        wait_idle(800);
        check_eq("prio_writes", wr_cnt - wr0, 152);

        // Reset in the middle of a draw
        push_obj(1, 1'b1);
        wr0 = wr_cnt; seen = 1'b0;
        enable[1] = 1'b1;
        wait_writes(wr0 + 20);
        @(negedge CLOCK_50);
        reset = 1'b1;
        exp_q.delete();
        @(posedge CLOCK_50); #2;
        check_eq("midrst_write", 32'(write), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_x", 32'(x), 0);
        @(negedge CLOCK_50);
        seen = 1'b0;
        push_all();
        wr0 = wr_cnt; busy_cnt = 0;
        reset = 1'b0;
        wait_idle(2000);
        check_eq("rerepaint_writes", wr_cnt - wr0, 752);
        check_eq("rerepaint_busy", busy_cnt, 766);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
